sram_bank_ctrl: RTL and testbench

Parametrised successor to the fixed 64-bit/64-entry banked SRAM wrapper. It builds a memory of N_BANK banks, each BW_DATA wide and split into BW_SLICE-wide spsram instances. A valid/ready request port adds byte-enable writes through an internal read-modify-write (RMW) sequence and returns registered read responses with a valid strobe. It sits between a bus-side master and the spsram macros.

---
 rtl/sram_bank_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_ctrl.sv
// sram_bank_ctrl: banked SRAM controller with a valid/ready request port.
//   Builds N_BANK banks of BW_DATA bits, each made of BW_DATA/BW_SLICE
//   spsram instances. Byte-enable writes that are neither full nor empty
//   go through a two-cycle read-modify-write. Reads return a registered
//   response strobe one cycle after acceptance.
// Optional feature macro: SRAM_BANK_CTRL_OREG_EN adds an output register
//   stage (read latency 2, throughput unchanged).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_we, i_req_addr, i_req_wdata, i_req_be
//                       request channel (be only meaningful for writes)
//   o_rsp_valid, o_rsp_rdata   read response; rdata holds when valid=0

// Single-port SRAM macro model: cen selects, wen=1 writes, read data is
// registered and shows up the cycle after the read access.
module spsram #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_cen,
  input  logic               i_wen,
  input  logic               i_oen,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic [BW_DATA-1:0] i_wdata,
  output logic [BW_DATA-1:0] o_rdata
);
  logic [BW_DATA-1:0] mem_q [0:(1<<BW_ADDR)-1];
  logic [BW_DATA-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_cen) begin
      if (i_wen) mem_q[i_addr] <= i_wdata;
      else       rdata_q       <= mem_q[i_addr];
    end
  end

  assign o_rdata = i_oen ? rdata_q : '0;
endmodule

module sram_bank_ctrl #(
  parameter  int BW_DATA      = 64,
  parameter  int BW_SLICE     = 32,
  parameter  int N_BANK       = 4,
  parameter  int BW_BANK_ADDR = 4,
  localparam int BW_ADDR      = $clog2(N_BANK) + BW_BANK_ADDR,
  localparam int BW_BE        = BW_DATA / 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [BW_ADDR-1:0] i_req_addr,
  input  logic [BW_DATA-1:0] i_req_wdata,
  input  logic [BW_BE-1:0]   i_req_be,
  output logic               o_rsp_valid,
  output logic [BW_DATA-1:0] o_rsp_rdata
);
  localparam int NB_W    = $clog2(N_BANK);
  localparam int N_SLICE = BW_DATA / BW_SLICE;

  typedef enum logic {IDLE, MERGE} state_e;

  state_e             state_q, state_d;
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic [BW_DATA-1:0] wdata_q, wdata_d;
  logic [BW_BE-1:0]   be_q, be_d;
  logic [NB_W-1:0]    rbank_q, rbank_d;
  logic               rd_pend_q, rd_pend_d;

  logic                           acc, wen;
  logic [BW_ADDR-1:0]             acc_addr;
  logic [BW_DATA-1:0]             acc_wdata, merged, rsp_data;
  logic [N_BANK-1:0]              cen;
  logic [N_BANK-1:0][BW_DATA-1:0] bank_rdata;
  logic                           rsp_v;

  // Old word of the RMW target comes straight from the bank read issued
  // in the previous (IDLE) cycle.
  always_comb begin
    merged = '0;
    for (int k = 0; k < BW_BE; k++)
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8]
                                 : bank_rdata[addr_q[BW_ADDR-1 -: NB_W]][8*k +: 8];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rbank_d     = rbank_q;
    rd_pend_d   = 1'b0;
    acc         = 1'b0;
    wen         = 1'b0;
    acc_addr    = i_req_addr;
    acc_wdata   = i_req_wdata;
    o_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (!i_req_we) begin
            acc       = 1'b1;
            rd_pend_d = 1'b1;
            rbank_d   = i_req_addr[BW_ADDR-1 -: NB_W];
          end else if (&i_req_be) begin
            acc = 1'b1;
            wen = 1'b1;
          end else if (|i_req_be) begin
            // partial write: fetch the old word now, merge next cycle
            acc     = 1'b1;
            addr_d  = i_req_addr;
            wdata_d = i_req_wdata;
            be_d    = i_req_be;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        acc       = 1'b1;
        wen       = 1'b1;
        acc_addr  = addr_q;
        acc_wdata = merged;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset kills any access, including a pending RMW write
    if (i_rst) acc = 1'b0;
  end

  always_comb begin
    cen = '0;
    for (int b = 0; b < N_BANK; b++)
      cen[b] = acc && (acc_addr[BW_ADDR-1 -: NB_W] == NB_W'(b));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rbank_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rbank_q   <= rbank_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
      spsram #(.BW_DATA(BW_SLICE), .BW_ADDR(BW_BANK_ADDR)) u_ram (
        .i_clk   (i_clk),
        .i_cen   (cen[b]),
        .i_wen   (wen),
        .i_oen   (1'b1),
        .i_addr  (acc_addr[BW_BANK_ADDR-1:0]),
        .i_wdata (acc_wdata[s*BW_SLICE +: BW_SLICE]),
        .o_rdata (bank_rdata[b][s*BW_SLICE +: BW_SLICE])
      );
    end
  end

  // a reset in the cycle after a read suppresses its response
  assign rsp_v    = rd_pend_q & ~i_rst;
  assign rsp_data = bank_rdata[rbank_q];

`ifdef SRAM_BANK_CTRL_OREG_EN
  logic               oreg_v_q;
  logic [BW_DATA-1:0] oreg_d_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oreg_v_q <= 1'b0;
      oreg_d_q <= '0;
    end else begin
      oreg_v_q <= rsp_v;
      if (rsp_v) oreg_d_q <= rsp_data;
    end
  end

  assign o_rsp_valid = oreg_v_q;
  assign o_rsp_rdata = oreg_d_q;
`else
  logic [BW_DATA-1:0] hold_q, hold_d;

  assign hold_d = rsp_v ? rsp_data : hold_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign o_rsp_valid = rsp_v;
  assign o_rsp_rdata = rsp_v ? rsp_data : hold_q;
`endif
endmodule

// File: tb/tb_sram_bank_ctrl.sv
`timescale 1ns/1ps
module tb_sram_bank_ctrl;
`ifdef SRAM_BANK_CTRL_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst, i_req_valid, o_req_ready, i_req_we, o_rsp_valid;
  logic [5:0]  i_req_addr;
  logic [63:0] i_req_wdata, o_rsp_rdata;
  logic [7:0]  i_req_be;

  sram_bank_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_be(i_req_be), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata)
  );

  // second instance for the wide / 8-bank configuration
  logic         rst2, v2, rdy2, we2, rv2;
  logic [6:0]   a2;
  logic [127:0] wd2, rd2;
  logic [15:0]  be2;

  sram_bank_ctrl #(.BW_DATA(128), .BW_SLICE(32), .N_BANK(8), .BW_BANK_ADDR(4)) dut2 (
    .i_clk(i_clk), .i_rst(rst2), .i_req_valid(v2), .o_req_ready(rdy2),
    .i_req_we(we2), .i_req_addr(a2), .i_req_wdata(wd2),
    .i_req_be(be2), .o_rsp_valid(rv2), .o_rsp_rdata(rd2)
  );

  // ---------------- model ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic [63:0] mem_m [0:63];
  exp_t        q[$];
  int          cyc = 0;
  int          merge_cyc = -1;
  logic [63:0] last_m = '0;
  bit          armed = 0;
  int          vcnt = 0;
  int          nchk = 0, nerr = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (armed) begin
      if (o_rsp_valid) vcnt++;
      if (i_rst) begin
        check("rsp_valid_in_reset", 128'(o_rsp_valid), 128'(0));
        q.delete();
        last_m = '0;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) begin
          nchk++; nerr++;
          $display("FAIL rsp_missing: no response for due cycle %0d, now %0d", q[0].due, cyc);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          check("rsp_valid", 128'(o_rsp_valid), 128'(1));
          check("rsp_rdata", 128'(o_rsp_rdata), 128'(q[0].data));
          last_m = q[0].data;
          void'(q.pop_front());
        end else begin
          check("rsp_valid_idle", 128'(o_rsp_valid), 128'(0));
          check("rsp_rdata_hold", 128'(o_rsp_rdata), 128'(last_m));
        end
        check("req_ready", 128'(o_req_ready), 128'(cyc != merge_cyc));
      end
    end
  end

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  // issue one request; model updated at acceptance
  task automatic do_req(input logic we, input logic [5:0] a, input logic [63:0] wd,
                        input logic [7:0] be, input bit apply, output logic [3:0] cen_s);
    logic rdy;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = wd; i_req_be = be;
    rdy = 1'b0;
    cen_s = '0;
    for (int t = 0; t < 8 && !rdy; t++) begin
      @(negedge i_clk);
      rdy   = o_req_ready;
      cen_s = dut.cen;
      tick();
    end
    i_req_valid = 1'b0;
    if (!rdy) begin
      nchk++; nerr++;
      $display("FAIL req_accept: addr %0h never accepted", a);
      return;
    end
    if (!we) q.push_back('{cyc + LAT - 1, mem_m[a]});
    else begin
      if (apply)
        for (int k = 0; k < 8; k++)
          if (be[k]) mem_m[a][8*k +: 8] = wd[8*k +: 8];
      if (be != 8'h00 && be != 8'hFF) merge_cyc = cyc;
    end
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [63:0] exp, input string nm);
    logic [3:0] c;
    do_req(1'b0, a, 64'h0, 8'h0, 1'b1, c);
    repeat (LAT - 1) tick();
    @(negedge i_clk);
    check({nm, "_valid"}, 128'(o_rsp_valid), 128'(1));
    check(nm, 128'(o_rsp_rdata), 128'(exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]   c;
    logic [127:0] one, d;
    int           a, n;
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_req_be = '0;
    rst2 = 1'b1; v2 = 1'b0; we2 = 1'b0; a2 = '0; wd2 = '0; be2 = '1;
    one = 128'd1;
    tick();
    armed = 1;
    tick();
    i_rst = 1'b0; rst2 = 1'b0;

    // reset state
    @(negedge i_clk);
    check("reset_ready", 128'(o_req_ready), 128'(1));
    check("reset_valid", 128'(o_rsp_valid), 128'(0));
    check("reset_rdata", 128'(o_rsp_rdata), 128'(0));
    check("reset_cen", 128'(dut.cen), 128'(0));
    tick();

    // fill all 64 words, then read them back-to-back
    for (int i = 0; i < 64; i++)
      do_req(1'b1, 6'(i), {32'(i), ~32'(i)}, 8'hFF, 1'b1, c);
    vcnt = 0;
    for (int i = 0; i < 64; i++)
      do_req(1'b0, 6'(i), 64'h0, 8'h0, 1'b1, c);
    repeat (LAT + 1) tick();
    check("burst_valid_count", 128'(vcnt), 128'(64));
    rd_chk(6'h05, 64'h00000005_FFFFFFFA, "rd_05");

    // partial write via RMW
    do_req(1'b1, 6'h25, 64'h1122334455667788, 8'hFF, 1'b1, c);
    do_req(1'b1, 6'h25, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b1, c);
    @(negedge i_clk);
    check("merge_ready_low", 128'(o_req_ready), 128'(0));
    tick();
    @(negedge i_clk);
    check("merge_ready_back", 128'(o_req_ready), 128'(1));
    tick();
    rd_chk(6'h25, 64'h11223344BBBBBBBB, "rmw_25");

    // be all zeros: no access
    do_req(1'b1, 6'h10, 64'hDEAD, 8'hFF, 1'b1, c);
    do_req(1'b1, 6'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, c);
    check("be0_cen", 128'(c), 128'(0));
    rd_chk(6'h10, 64'hDEAD, "be0_10");

    // reset during MERGE drops the write
    do_req(1'b1, 6'h30, 64'h0, 8'hFF, 1'b1, c);
    do_req(1'b1, 6'h30, 64'hFFFFFFFFFFFFFFFF, 8'h3C, 1'b0, c);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_merge_cen", 128'(dut.cen), 128'(0));
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_merge_ready", 128'(o_req_ready), 128'(1));
    tick();
    rd_chk(6'h30, 64'h0, "rst_merge_30");

    // write then immediate read of 0x3F, bank 3 only
    do_req(1'b1, 6'h3F, 64'hCAFEBABE01234567, 8'hFF, 1'b1, c);
    check("wr3f_cen", 128'(c), 128'(4'b1000));
    do_req(1'b0, 6'h3F, 64'h0, 8'h0, 1'b1, c);
    check("rd3f_cen", 128'(c), 128'(4'b1000));
    repeat (LAT - 1) tick();
    @(negedge i_clk);
    check("rd3f_valid", 128'(o_rsp_valid), 128'(1));
    check("rd3f_data", 128'(o_rsp_rdata), 128'(64'hCAFEBABE01234567));
    tick();

    // scattered byte enables, then RMW immediately followed by reads
    do_req(1'b1, 6'h07, 64'h0102030405060708, 8'hA5, 1'b1, c);
    rd_chk(6'h07, 64'h01000307FF06FF08, "rmw_07");
    do_req(1'b1, 6'h1A, 64'h5555555555555555, 8'h80, 1'b1, c);
    do_req(1'b0, 6'h1A, 64'h0, 8'h0, 1'b1, c);
    do_req(1'b1, 6'h2B, 64'h6666666666666666, 8'h01, 1'b1, c);
    do_req(1'b0, 6'h2B, 64'h0, 8'h0, 1'b1, c);
    do_req(1'b0, 6'h3F, 64'h0, 8'h0, 1'b1, c);
    repeat (LAT + 1) tick();

    // reset right after an accepted read suppresses the response
    do_req(1'b0, 6'h01, 64'h0, 8'h0, 1'b1, c);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_suppress_valid", 128'(o_rsp_valid), 128'(0));
    tick();
    i_rst = 1'b0;
    repeat (2) tick();
    @(negedge i_clk);
    check("idle_cen", 128'(dut.cen), 128'(0));
    check("idle_valid", 128'(o_rsp_valid), 128'(0));
    tick();

    // 8 banks x 128 bit: walking one at first/last word of each bank
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 2; k++) begin
        a = b * 16 + k * 15;
        n = (b * 2 + k) * 7;
        v2 = 1'b1; we2 = 1'b1; a2 = 7'(a); wd2 = one << n; be2 = '1;
        @(negedge i_clk);
        check("sweep_wr_ready", 128'(rdy2), 128'(1));
        tick();
        v2 = 1'b0;
      end
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 2; k++) begin
        a = b * 16 + k * 15;
        n = (b * 2 + k) * 7;
        d = one << n;
        v2 = 1'b1; we2 = 1'b0; a2 = 7'(a);
        tick();
        v2 = 1'b0;
        repeat (LAT - 1) tick();
        @(negedge i_clk);
        check("sweep_rd_valid", 128'(rv2), 128'(1));
        check("sweep_rd_data", rd2, d);
        tick();
      end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
